// File: rtl/floo_ring_on_mesh_mcast_fork.sv
//------------------------------------------------------------------------------
// Module   : floo_ring_on_mesh_mcast_fork
// Brief    : Zero-latency flit fork that replicates one flit to every output in its route mask.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module floo_ring_on_mesh_mcast_fork #(
  parameter int unsigned NumRoutes    = 5,
  parameter type         flit_t       = logic,
  parameter int unsigned DropCntWidth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  flit_t                   channel_i,
  input  logic [NumRoutes-1:0]    route_sel_i,
  output logic [NumRoutes-1:0]    valid_o,
  input  logic [NumRoutes-1:0]    ready_i,
  output flit_t                   channel_o,
  output logic                    busy_o,
  output logic                    drop_o,
  output logic [DropCntWidth-1:0] drop_cnt_o
);

  logic [NumRoutes-1:0]    r_sent;
  logic [DropCntWidth-1:0] r_drop_cnt;
  logic [NumRoutes-1:0]    w_pending;
  logic                    w_done;

  // Outputs that already took the current flit are masked so they never see it twice.
  assign w_pending  = route_sel_i & ~r_sent;
  assign valid_o    = {NumRoutes{valid_i}} & w_pending;
  assign ready_o    = ((w_pending & ~ready_i) == '0);
  assign channel_o  = channel_i;
  assign w_done     = valid_i & ready_o;
  assign drop_o     = valid_i & (route_sel_i == '0);
  assign busy_o     = |r_sent;
  assign drop_cnt_o = r_drop_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sent <= '0;
    end else if (w_done) begin
      r_sent <= '0;
    end else if (valid_i) begin
      r_sent <= r_sent | (valid_o & ready_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_drop_cnt <= '0;
    end else if (drop_o && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + DropCntWidth'(1);
    end
  end

`ifndef SYNTHESIS
  // The mask is locked per packet upstream; a change mid-delivery would corrupt the fork.
  logic [NumRoutes-1:0] r_route_sel_prev;

  always @(posedge clk_i) begin
    r_route_sel_prev <= route_sel_i;
    if (rst_ni && busy_o && (route_sel_i != r_route_sel_prev)) begin
      $warning("route_sel_i changed while a flit is partially delivered");
    end
  end
`endif

endmodule

`default_nettype wire
